// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its downstream result buffer.
// Holds the op-code constants, the datapath width and the packed layout
// of one buffered result entry.
package alu_pkg;

    localparam int ALU_DW = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // One stored entry: op code, negative flag, zero flag, result data.
    typedef struct packed {
        logic [1:0]        op;
        logic              n;
        logic              z;
        logic [ALU_DW-1:0] data;
    } alu_entry_t;

    localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_result_mem.sv
// Storage array for the ALU result buffer: DEPTH words of W bits with one
// synchronous write port and one asynchronous read port. Contents are
// deliberately not reset; occupancy is tracked by the owning buffer.
module alu_result_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write the addressed slot when the buffer accepts an entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_buf.sv
// Result buffer behind the 4-bit ALU: a small FIFO with valid/ready on both
// sides that stores each result with its op code and precomputed N/Z flags.
// Entries become visible one clock after they are pushed (no fall-through).
// Optional statistics counters are enabled with `define ALU_RESULT_BUF_STATS_EN.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ALU_DW
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic [DW-1:0]              res_i,
    input  logic [1:0]                 op_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [DW-1:0]              data_o,
    output logic [1:0]                 op_o,
    output logic                       n_o,
    output logic                       z_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
`ifdef ALU_RESULT_BUF_STATS_EN
    ,
    output logic [7:0]                 push_cnt_o,
    output logic [7:0]                 stall_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + 4;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Handshake status is derived from the registered count only, so
    // ready_o never depends combinationally on ready_i.
    assign ready_o = (count != CW'(DEPTH));
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign count_o = count;

    // Flags are computed from the incoming result, not from the stored data.
    assign wr_entry = {op_i, res_i[DW-1], (res_i == '0), res_i};

    alu_result_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk     (clk_i),
        .we      (push && !flush_i),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // Head outputs read straight from the slot at rd_ptr, zeroed when empty.
    always_comb begin
        data_o = '0;
        op_o   = '0;
        n_o    = 1'b0;
        z_o    = 1'b0;
        if (valid_o) begin
            data_o = rd_entry[DW-1:0];
            z_o    = rd_entry[DW];
            n_o    = rd_entry[DW+1];
            op_o   = rd_entry[DW+3:DW+2];
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle transfer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef ALU_RESULT_BUF_STATS_EN
    // Accepted-push counter wraps; stall counter saturates at its maximum.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            push_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            push_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (push) begin
                push_cnt_o <= push_cnt_o + 8'd1;
            end
            if (valid_i && !ready_o && (stall_cnt_o != 8'hFF)) begin
                stall_cnt_o <= stall_cnt_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Self-checking bench for alu_result_buf: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
// Build with +define+ALU_RESULT_BUF_STATS_EN to cover the statistics counters.
module tb_alu_result_buf;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       flush_i;
    logic [3:0] res_i;
    logic [1:0] op_i;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] data_o;
    logic [1:0] op_o;
    logic       n_o;
    logic       z_o;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] count_o;
`ifdef ALU_RESULT_BUF_STATS_EN
    logic [7:0] push_cnt_o;
    logic [7:0] stall_cnt_o;
`endif

    alu_result_buf #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .res_i   (res_i),
        .op_i    (op_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .op_o    (op_o),
        .n_o     (n_o),
        .z_o     (z_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .count_o (count_o)
`ifdef ALU_RESULT_BUF_STATS_EN
        ,
        .push_cnt_o  (push_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] d;
        logic [1:0] op;
    } ent_t;

    ent_t model_q[$];
    int   push_total;
    int   stall_total;
    int   checks;
    int   errors;

    // Values the DUT showed during the most recent applyStimulus cycle.
    logic [3:0] last_data;
    logic [1:0] last_op;
    logic       last_n;
    logic       last_z;
    logic       last_valid;
    logic       last_ready;
    logic [2:0] last_count;
    logic [7:0] last_stall;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Compare every output with what the model says the head looks like now.
    task automatic compareAll();
        logic [3:0] e_d;
        logic [1:0] e_op;
        e_d  = 4'd0;
        e_op = 2'd0;
        if (model_q.size() > 0) begin
            e_d  = model_q[0].d;
            e_op = model_q[0].op;
        end
        checkOutput("valid_o", 32'(valid_o), 32'(model_q.size() > 0));
        checkOutput("ready_o", 32'(ready_o), 32'(model_q.size() < DEPTH));
        checkOutput("count_o", 32'(count_o), 32'(model_q.size()));
        checkOutput("data_o",  32'(data_o),  32'(e_d));
        checkOutput("op_o",    32'(op_o),    32'(e_op));
        checkOutput("n_o",     32'(n_o),     32'((model_q.size() > 0) && e_d >= 4'd8));
        checkOutput("z_o",     32'(z_o),     32'((model_q.size() > 0) && e_d == 4'd0));
`ifdef ALU_RESULT_BUF_STATS_EN
        checkOutput("push_cnt_o",  32'(push_cnt_o),  32'(push_total));
        checkOutput("stall_cnt_o", 32'(stall_cnt_o), 32'(stall_total));
        last_stall = stall_cnt_o;
`else
        last_stall = 8'd0;
`endif
        last_data  = data_o;
        last_op    = op_o;
        last_n     = n_o;
        last_z     = z_o;
        last_valid = valid_o;
        last_ready = ready_o;
        last_count = count_o;
    endtask

    // Drive one clock cycle of inputs, check outputs, then advance the model.
    task automatic applyStimulus(input logic v, input logic r, input logic f,
                                 input logic [3:0] res, input logic [1:0] op);
        bit   do_push;
        bit   do_pop;
        bit   stalled;
        ent_t e;
        @(negedge clk_i);
        valid_i = v;
        ready_i = r;
        flush_i = f;
        res_i   = res;
        op_i    = op;
        #1;
        compareAll();
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        stalled = v && (model_q.size() == DEPTH);
        e.d  = res;
        e.op = op;
        @(posedge clk_i);
        if (f) begin
            model_q.delete();
            push_total  = 0;
            stall_total = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(e);
                push_total = (push_total + 1) % 256;
            end
            if (stalled && stall_total < 255) stall_total++;
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    endtask

    initial begin
        logic [3:0] fill_vals [4];
        logic [3:0] wrap_exp  [12];
        checks      = 0;
        errors      = 0;
        push_total  = 0;
        stall_total = 0;
        rst_n_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        res_i   = 4'd0;
        op_i    = 2'd0;

        // Reset then idle.
        repeat (2) @(negedge clk_i);
        #1;
        compareAll();
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_count", 32'(count_o), 32'd0);
        rst_n_i = 1'b1;
        idle();

        // Single push then pop.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 2'b01);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        checkOutput("single_valid", 32'(last_valid), 32'd1);
        checkOutput("single_data",  32'(last_data),  32'd8);
        checkOutput("single_op",    32'(last_op),    32'd1);
        checkOutput("single_n",     32'(last_n),     32'd1);
        checkOutput("single_z",     32'(last_z),     32'd0);
        checkOutput("single_count", 32'(last_count), 32'd1);
        idle();
        checkOutput("single_drain", 32'(last_count), 32'd0);

        // Fill to capacity, then attempt blocked pushes for 3 cycles.
        fill_vals[0] = 4'd0;
        fill_vals[1] = 4'd3;
        fill_vals[2] = 4'd5;
        fill_vals[3] = 4'd7;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, fill_vals[i], 2'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 2'd3);
        checkOutput("fill_count", 32'(last_count), 32'd4);
        checkOutput("fill_ready", 32'(last_ready), 32'd0);
        checkOutput("fill_head_z", 32'(last_z), 32'd1);
        idle();
`ifdef ALU_RESULT_BUF_STATS_EN
        checkOutput("fill_stall3", 32'(last_stall), 32'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
            checkOutput("fill_order", 32'(last_data), 32'(fill_vals[i]));
        end
        idle();
        checkOutput("fill_empty", 32'(last_valid), 32'd0);

        // Wrap-around: steady push/pop at occupancy 2.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd11, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd12, 2'd0);
        wrap_exp[0] = 4'd11;
        wrap_exp[1] = 4'd12;
        for (int i = 1; i <= 10; i++) wrap_exp[i+1] = 4'(i);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'(i), 2'd2);
            checkOutput("wrap_count", 32'(last_count), 32'd2);
            checkOutput("wrap_order", 32'(last_data), 32'(wrap_exp[i-1]));
        end
        for (int i = 11; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
            checkOutput("wrap_tail", 32'(last_data), 32'(wrap_exp[i-1]));
        end

        // Flush at occupancy 3 together with a push.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd4, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 2'd0);
        checkOutput("flush_pre_count", 32'(last_count), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd6, 2'd1);
        checkOutput("flush_count", 32'(last_count), 32'd0);
        checkOutput("flush_valid", 32'(last_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        checkOutput("flush_next", 32'(last_data), 32'd6);
        idle();

        // Asynchronous reset between clock edges at occupancy 2.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd13, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd14, 2'd3);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        checkOutput("pre_rst_count", 32'(count_o), 32'd2);
        #1;
        rst_n_i = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(valid_o), 32'd0);
        checkOutput("arst_ready", 32'(ready_o), 32'd1);
        checkOutput("arst_count", 32'(count_o), 32'd0);
`ifdef ALU_RESULT_BUF_STATS_EN
        checkOutput("arst_push_cnt", 32'(push_cnt_o), 32'd0);
`endif
        model_q.delete();
        push_total  = 0;
        stall_total = 0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle();

        // Randomized traffic including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 31) == 0),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buf.md
Name: alu_result_buf

Overview:
- Downstream stage of the 4-bit ALU.
- Captures each ALU result R_o with its 2-bit operation code Control_i into a small FIFO, and presents entries to the consumer in order.
- Uses a valid/ready handshake on both sides, so a stalled consumer never loses a result.
- Derives and stores N/Z status flags per entry, so the consumer does not need to recompute them.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, DEPTH >= 2.
- DW, 4, result data width; matches the ALU datapath.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all entries.
- res_i  in  DW  ALU result (R_o of the ALU).
- op_i  in  2  ALU operation code that produced res_i: 00 add, 01 sub, 10 or, 11 and.
- valid_i  in  1  res_i/op_i valid this cycle.
- ready_o  out  1  buffer can accept an entry.
- data_o  out  DW  head-entry result.
- op_o  out  2  head-entry operation code.
- n_o  out  1  head-entry negative flag: data_o[DW-1] at capture.
- z_o  out  1  head-entry zero flag: res_i == 0 at capture.
- valid_o  out  1  head entry valid.
- ready_i  in  1  consumer accepts the head entry.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Push: valid_i && ready_o at a rising edge. Pop: valid_o && ready_i at a rising edge.
- ready_o = (count != DEPTH). It depends only on registered state; there is no combinational path from ready_i to ready_o.
- valid_o = (count != 0). There is no fall-through: an entry pushed in cycle t is first visible with valid_o=1 in cycle t+1. Latency is 1 clock.
- data_o, op_o, n_o, z_o are read combinationally from the storage slot at rd_ptr. All four are forced to 0 while count == 0.
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is tracked by an explicit count register, not by pointer comparison.
- Both push and pop in the same cycle:
  - Count is unchanged; both pointers advance.
  - Legal at any occupancy 0<count<DEPTH.
  - At count==DEPTH, push is blocked because ready_o=0; only the pop occurs.
  - At count==0, pop is blocked because valid_o=0; only the push occurs.
- Push with valid_i=1 while ready_o=0: not accepted. Holding res_i/op_i stable is the producer's responsibility.
- flush_i=1:
  - Next edge sets wr_ptr=0, rd_ptr=0, count=0.
  - Overrides any push or pop in the same cycle; that entry is dropped.
  - Storage contents are not cleared.
- Reset (rst_n_i low, asynchronous at any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, so valid_o=0 and ready_o=1, data_o/op_o/n_o/z_o=0.
  - Storage array is not reset.
- n_o and z_o are computed from res_i at push time and stored per entry, never from data_o at pop.
- No internal state machine beyond the pointer/count registers.

Optional Feature:
- Macro: ALU_RESULT_BUF_STATS_EN.
- When defined:
  - Adds output push_cnt_o (8 bits): total accepted pushes, wraps at 255->0.
  - Adds output stall_cnt_o (8 bits): cycles with valid_i=1 && ready_o=0, saturating at 255.
  - Both counters reset to 0 on rst_n_i and clear on flush_i.
- When undefined: the two ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op-code constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_AND=2'b11.
  - ALU data width constant ALU_DW=4.
  - The packed entry layout {op, n, z, data}, 8 bits wide at DW=4.
- One natural sub-module, alu_result_mem: a DEPTH x (DW+4) register array with one write port and one asynchronous read port.
- Pointer, count and flag logic stay in alu_result_buf.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n_i low for 2 cycles, then high.
  - Required: valid_o=0, ready_o=1, count_o=0, data_o=0.
- Single push:
  - Stimulus: push res_i=4'b1000, op_i=01.
  - Required next cycle: valid_o=1, data_o=8, op_o=01, n_o=1, z_o=0, count_o=1.
  - Then pop with ready_i=1. Required: count_o=0, valid_o=0.
- Fill:
  - Stimulus: push 0,3,5,7 with op 00,01,10,11 and ready_i=0.
  - Required: count_o=4, ready_o=0. First entry z_o=1.
  - Stimulus: a 5th push with valid_i=1 is attempted. Required: it is ignored, and popping yields 0,3,5,7 in order.
- Wrap-around:
  - Stimulus: 10 continuous push/pop cycles at count=2 with values 1..10.
  - Required: output order 1..10, count_o stays 2, pointers wrap with no loss.
- Flush:
  - Stimulus: at count=3, assert flush_i together with a push of 9.
  - Required next cycle: count_o=0, valid_o=0. A subsequent push of 6 appears as data_o=6.
- Async reset mid-operation:
  - Stimulus: at count=2, drop rst_n_i between clock edges.
  - Required immediately: valid_o=0, ready_o=1, count_o=0.
  - With ALU_RESULT_BUF_STATS_EN: push_cnt_o=0, and stall_cnt_o counts 3 blocked cycles exactly in a prior full-stall phase.
